// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: 16x-oversampled UART receiver with per-char error flags
// feeding a first-word-fall-through FIFO, plus break and idle-timeout detect.
//
// Ports:
//   CLK, RESET_N   clock, async active-low reset
//   BAUD_TICK16    1-CLK pulse at 16x baud
//   RX             async serial input, idle high
//   PARITY_EN      parity bit follows data
//   ODD_N_EVEN     1 = odd parity, 0 = even
//   RD_EN          pop FIFO head
//   CLR_OVF        clear OVERFLOW
//   DATA_OUT       head data (0 when empty)
//   PARITY_ERR     head parity error flag
//   FRAMING_ERR    head framing error flag
//   RXRDY          FIFO not empty
//   OVERFLOW       sticky drop flag
//   BREAK_DET      1-CLK pulse per break
//   TIMEOUT        FIFO non-empty and line idle long enough
//   LEVEL          FIFO occupancy
module uart_rx_fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          BAUD_TICK16,
  input  logic                          RX,
  input  logic                          PARITY_EN,
  input  logic                          ODD_N_EVEN,
  input  logic                          RD_EN,
  input  logic                          CLR_OVF,
  output logic [DATA_WIDTH-1:0]         DATA_OUT,
  output logic                          PARITY_ERR,
  output logic                          FRAMING_ERR,
  output logic                          RXRDY,
  output logic                          OVERFLOW,
  output logic                          BREAK_DET,
  output logic                          TIMEOUT,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [3:0]  LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TO_MAX   = 8'(TIMEOUT_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                  state;
  logic                    rx_m;
  logic                    rx_s;
  logic [1:0]              vote_sr;
  logic [3:0]              tick_cnt;
  logic [3:0]              cnt_n;
  logic [3:0]              bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bit;
  logic                    perr;
  logic                    vote;
  logic                    mid;
  logic                    start_edge;
  logic                    stop_now;
  logic                    brk;
  logic                    wr_req;
  logic [EW-1:0]           wr_word;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [EW-1:0]           head;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  logic [3:0]              to_div;
  logic [7:0]              to_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // vote_sr holds the two previous tick samples; with the current
  // sample they form the ticks 7,8,9 vote at a bit centre.
  assign vote = (vote_sr[1] & vote_sr[0])
              | (vote_sr[1] & rx_s)
              | (vote_sr[0] & rx_s);
  assign cnt_n = tick_cnt + 4'd1;
  assign mid   = (cnt_n == 4'd9);

  assign start_edge = BAUD_TICK16 && (state == S_IDLE)
                   && vote_sr[0] && !rx_s;
  assign stop_now   = BAUD_TICK16 && (state == S_STOP) && mid;
  assign brk        = stop_now && !vote && (shreg == '0) && !par_bit;
  assign wr_req     = stop_now && !brk;
  assign wr_word    = {!vote, perr, shreg};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      vote_sr   <= 2'b11;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      perr      <= 1'b0;
      BREAK_DET <= 1'b0;
    end else begin
      BREAK_DET <= 1'b0;
      if (BAUD_TICK16) begin
        vote_sr  <= {vote_sr[0], rx_s};
        tick_cnt <= cnt_n;
        unique case (state)
          S_IDLE: begin
            if (vote_sr[0] && !rx_s) begin
              state    <= S_START;
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_bit  <= 1'b0;
              perr     <= 1'b0;
            end
          end
          S_START: begin
            if (mid) state <= vote ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            if (mid) begin
              shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT)
                state <= PARITY_EN ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            if (mid) begin
              par_bit <= vote;
              perr    <= (^shreg) ^ vote ^ ODD_N_EVEN;
              state   <= S_STOP;
            end
          end
          S_STOP: begin
            if (mid) begin
              if (brk) begin
                BREAK_DET <= 1'b1;
                state     <= S_WAIT_HIGH;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_WAIT_HIGH: begin
            if (rx_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty = (LEVEL == '0);
  assign full  = (LEVEL == FULL_LVL);
  assign pop   = RD_EN && !empty;
  // A full FIFO still takes a char when a pop frees the head slot.
  assign push  = wr_req && (!full || pop);
  assign drop  = wr_req && full && !RD_EN;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      LEVEL    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      LEVEL <= LEVEL + 1'b1;
      else if (pop && !push) LEVEL <= LEVEL - 1'b1;
      if (drop)         OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign DATA_OUT    = empty ? '0 : head[DATA_WIDTH-1:0];
  assign PARITY_ERR  = !empty && head[DATA_WIDTH];
  assign FRAMING_ERR = !empty && head[DATA_WIDTH+1];
  assign RXRDY       = !empty;

  // Idle bit-time counter; saturates at the threshold so TIMEOUT holds.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_div <= '0;
      to_cnt <= '0;
    end else if (start_edge || RD_EN) begin
      to_div <= '0;
      to_cnt <= '0;
    end else if (BAUD_TICK16 && (state == S_IDLE)
                 && !empty && (to_cnt != TO_MAX)) begin
      to_div <= to_div + 4'd1;
      if (to_div == 4'd15) to_cnt <= to_cnt + 8'd1;
    end
  end

  assign TIMEOUT = !empty && (to_cnt == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb_uart_rx_fifo_param: directed plus randomized frames checked against
// a queue-based receive model.
module tb_uart_rx_fifo_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TB = 40;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic BAUD_TICK16 = 1'b0;
  logic RX = 1'b1;
  logic PARITY_EN = 1'b0;
  logic ODD_N_EVEN = 1'b0;
  logic RD_EN = 1'b0;
  logic CLR_OVF = 1'b0;
  logic [W-1:0] DATA_OUT;
  logic PARITY_ERR;
  logic FRAMING_ERR;
  logic RXRDY;
  logic OVERFLOW;
  logic BREAK_DET;
  logic TIMEOUT;
  logic [$clog2(D):0] LEVEL;

  uart_rx_fifo_param #(
    .DATA_WIDTH(W),
    .FIFO_DEPTH(D),
    .TIMEOUT_BITS(TB)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .BAUD_TICK16(BAUD_TICK16),
    .RX(RX),
    .PARITY_EN(PARITY_EN),
    .ODD_N_EVEN(ODD_N_EVEN),
    .RD_EN(RD_EN),
    .CLR_OVF(CLR_OVF),
    .DATA_OUT(DATA_OUT),
    .PARITY_ERR(PARITY_ERR),
    .FRAMING_ERR(FRAMING_ERR),
    .RXRDY(RXRDY),
    .OVERFLOW(OVERFLOW),
    .BREAK_DET(BREAK_DET),
    .TIMEOUT(TIMEOUT),
    .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         fe;
    logic         pe;
    logic [W-1:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   brk_cnt = 0;

  always @(negedge CLK) begin
    if (BREAK_DET === 1'b1) brk_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".level"}, 32'(LEVEL), 32'(q.size()));
    chk({tag, ".rxrdy"}, 32'(RXRDY), 32'(q.size() != 0));
    chk({tag, ".ovf"}, 32'(OVERFLOW), 32'(m_ovf));
    chk({tag, ".data"}, 32'(DATA_OUT), 32'(h.d));
    chk({tag, ".pe"}, 32'(PARITY_ERR), 32'(h.pe));
    chk({tag, ".fe"}, 32'(FRAMING_ERR), 32'(h.fe));
  endtask

  task automatic tick(input logic rd);
    repeat (3) @(negedge CLK);
    BAUD_TICK16 = 1'b1;
    RD_EN = rd;
    @(negedge CLK);
    BAUD_TICK16 = 1'b0;
    RD_EN = 1'b0;
  endtask

  task automatic bit_time(input logic b);
    RX = b;
    repeat (16) tick(1'b0);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) tick(1'b0);
  endtask

  // Sends one frame and stops right after the stop-bit sample tick.
  task automatic send_frame(input logic [W-1:0] d, input logic pen,
                            input logic odd, input logic pbit,
                            input logic stopb, input logic rd);
    ent_t e;
    logic brk;
    PARITY_EN = pen;
    ODD_N_EVEN = odd;
    bit_time(1'b0);
    for (int i = 0; i < W; i++) bit_time(d[i]);
    if (pen) bit_time(pbit);
    RX = stopb;
    repeat (9) tick(1'b0);
    chk("pre_stop.level", 32'(LEVEL), 32'(q.size()));
    tick(rd);
    e.d  = d;
    e.fe = !stopb;
    e.pe = pen && (pbit != ((^d) ^ odd));
    brk  = (d == '0) && !stopb && (!pen || !pbit);
    if (rd && q.size() != 0) void'(q.pop_front());
    if (!brk) begin
      if (q.size() < D) q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic read_one();
    @(negedge CLK);
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr_ovf();
    @(negedge CLK);
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    logic pen;
    logic odd;
    logic pbit;
    logic stopb;
    int b0;

    repeat (3) @(negedge CLK);
    check_state("reset");
    chk("reset.brk", 32'(BREAK_DET), 32'd0);
    chk("reset.to", 32'(TIMEOUT), 32'd0);
    RESET_N = 1'b1;
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("a5");
    chk("a5.const", 32'(DATA_OUT), 32'hA5);
    chk("a5.lvl1", 32'(LEVEL), 32'd1);

    idle(4);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    read_one();
    check_state("par");
    chk("par.data", 32'(DATA_OUT), 32'h07);
    chk("par.pe", 32'(PARITY_ERR), 32'd1);
    read_one();
    check_state("par.empty");

    idle(4);
    RX = 1'b0;
    repeat (4) tick(1'b0);
    idle(20);
    check_state("false");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("after_false");
    chk("after_false.data", 32'(DATA_OUT), 32'h3C);
    read_one();

    for (int i = 0; i < 5; i++) begin
      idle(2);
      send_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_state("ovf.step");
    end
    chk("ovf.level", 32'(LEVEL), 32'd4);
    chk("ovf.flag", 32'(OVERFLOW), 32'd1);
    chk("ovf.head", 32'(DATA_OUT), 32'h11);
    clr_ovf();
    check_state("ovf.clr");
    chk("ovf.cleared", 32'(OVERFLOW), 32'd0);

    idle(2);
    send_frame(8'h9E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_state("coinc");
    chk("coinc.level", 32'(LEVEL), 32'd4);
    chk("coinc.ovf", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_state("coinc.drain");
      read_one();
    end
    check_state("coinc.empty");

    idle(4);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    b0 = brk_cnt;
    RX = 1'b0;
    repeat (320) tick(1'b0);
    check_state("brk.low");
    chk("brk.pulses", 32'(brk_cnt - b0), 32'd1);
    idle(4);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("brk.after");
    chk("brk.level", 32'(LEVEL), 32'd2);
    read_one();
    read_one();

    idle(4);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (639) tick(1'b0);
    chk("to.before", 32'(TIMEOUT), 32'd0);
    tick(1'b0);
    chk("to.at", 32'(TIMEOUT), 32'd1);
    read_one();
    chk("to.cleared", 32'(TIMEOUT), 32'd0);
    chk("to.rxrdy", 32'(RXRDY), 32'd0);

    for (int i = 0; i < 30; i++) begin
      d = W'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      pbit = ((^d) ^ odd) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) != 0);
      send_frame(d, pen, odd, pbit, stopb, 1'b0);
      check_state("rnd");
      idle($urandom_range(2, 20));
      for (int r = 0; r < $urandom_range(0, 2); r++) begin
        read_one();
        check_state("rnd.rd");
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_ovf();
        check_state("rnd.clr");
      end
    end

    RX = 1'b0;
    repeat (40) tick(1'b0);
    RESET_N = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    @(negedge CLK);
    check_state("midrst");
    RX = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    idle(4);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("midrst.after");
    chk("midrst.level", 32'(LEVEL), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
